// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: EX and LSU share one register-file write port.
// LSU has fixed priority; EX gets a one-grant boost after STARVE_LIM lost cycles.
module wb_port_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_LIM = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          ex_starved
);

  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] lose_cnt_q, lose_cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          boost;

  // Boost comes from registered history only, so it is stable within a cycle.
  assign boost      = (lose_cnt_q >= LIM);
  assign ex_starved = boost && !rst;
  assign ex_ready   = !rst && ex_valid && (!lsu_valid || boost);
  assign lsu_ready  = !rst && lsu_valid && !(ex_valid && boost);

  always_comb begin
    lose_cnt_d = lose_cnt_q;
    if (!ex_valid || ex_ready) begin
      lose_cnt_d = '0;
    end else if (lose_cnt_q < LIM) begin
      lose_cnt_d = lose_cnt_q + CW'(1);
    end
  end

  // x0 writes complete the handshake and update addr/data, but never enable.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (ex_ready) begin
      rf_we_d    = (ex_rd != '0);
      rf_waddr_d = ex_rd;
      rf_wdata_d = ex_data;
    end else if (lsu_ready) begin
      rf_we_d    = (lsu_rd != '0);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lose_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      lose_cnt_q <= lose_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter with STARVE_LIM=3.
module tb_wb_port_arbiter;

  logic        clk, rst;
  logic        ex_valid, ex_ready, lsu_valid, lsu_ready;
  logic [4:0]  ex_rd, lsu_rd, rf_waddr;
  logic [31:0] ex_data, lsu_data, rf_wdata;
  logic        rf_we, ex_starved;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.DW(32), .AW(5), .STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ex_starved(ex_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        er;
    logic        lr;
    logic        st;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check readies at negedge, registered outputs after next edge.
  task automatic cyc(input vec_t v, input string tag);
    ex_valid = v.exv; ex_rd = v.exrd; ex_data = v.exd;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    @(negedge clk);
    chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(v.er));
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(v.lr));
    chk({tag, ".ex_starved"}, 32'(ex_starved), 32'(v.st));
    @(posedge clk);
    #1;
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(v.we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(v.wa));
    chk({tag, ".rf_wdata"}, rf_wdata, v.wd);
    $display("%s: exv=%0b lv=%0b -> er=%0b lr=%0b st=%0b | we=%0b wa=%0d wd=%0h",
             tag, v.exv, v.lv, ex_ready, lsu_ready, ex_starved, rf_we, rf_waddr, rf_wdata);
  endtask

  function automatic vec_t mk(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic er, input logic lr, input logic st,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.exv = exv; v.exrd = exrd; v.exd = exd; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.er = er; v.lr = lr; v.st = st; v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // EX alone, then idle (outputs drop, addr/data hold)
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           1, 0, 0, 1, 5, 32'hDEADBEEF);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0, 5, 32'hDEADBEEF);
    // Continuous contention: L L L E L L L E
    tbl[2]  = mk(1, 7, 32'h70, 1, 10, 32'hA0,           0, 1, 0, 1, 10, 32'hA0);
    tbl[3]  = mk(1, 7, 32'h70, 1, 11, 32'hA1,           0, 1, 0, 1, 11, 32'hA1);
    tbl[4]  = mk(1, 7, 32'h70, 1, 12, 32'hA2,           0, 1, 0, 1, 12, 32'hA2);
    tbl[5]  = mk(1, 7, 32'h70, 1, 13, 32'hA3,           1, 0, 1, 1, 7,  32'h70);
    tbl[6]  = mk(1, 8, 32'h80, 1, 13, 32'hA3,           0, 1, 0, 1, 13, 32'hA3);
    tbl[7]  = mk(1, 8, 32'h80, 1, 14, 32'hA4,           0, 1, 0, 1, 14, 32'hA4);
    tbl[8]  = mk(1, 8, 32'h80, 1, 15, 32'hA5,           0, 1, 0, 1, 15, 32'hA5);
    tbl[9]  = mk(1, 8, 32'h80, 1, 16, 32'hA6,           1, 0, 1, 1, 8,  32'h80);
    // x0 discard from LSU and from EX: handshake completes, no write enable
    tbl[10] = mk(0, 0, 0,        1, 0, 32'h1234,        0, 1, 0, 0, 0, 32'h1234);
    tbl[11] = mk(1, 0, 32'h55,   0, 0, 0,               1, 0, 0, 0, 0, 32'h55);
    // Starvation clear: two losses, EX idle one cycle, then three fresh losses
    tbl[12] = mk(1, 9, 32'h90, 1, 16, 32'hB0,           0, 1, 0, 1, 16, 32'hB0);
    tbl[13] = mk(1, 9, 32'h90, 1, 17, 32'hB1,           0, 1, 0, 1, 17, 32'hB1);
    tbl[14] = mk(0, 9, 32'h90, 1, 18, 32'hB2,           0, 1, 0, 1, 18, 32'hB2);
    tbl[15] = mk(1, 9, 32'h90, 1, 19, 32'hB3,           0, 1, 0, 1, 19, 32'hB3);
    tbl[16] = mk(1, 9, 32'h90, 1, 20, 32'hB4,           0, 1, 0, 1, 20, 32'hB4);
    tbl[17] = mk(1, 9, 32'h90, 1, 21, 32'hB5,           0, 1, 0, 1, 21, 32'hB5);
    tbl[18] = mk(1, 9, 32'h90, 1, 21, 32'hB5,           1, 0, 1, 1, 9,  32'h90);
    // Same rd back to back: later grant overwrites
    tbl[19] = mk(1, 3, 32'h33, 0, 0, 0,                 1, 0, 0, 1, 3, 32'h33);
    tbl[20] = mk(0, 0, 0,      1, 3, 32'h44,            0, 1, 0, 1, 3, 32'h44);
    tbl[21] = mk(0, 0, 0,      0, 0, 0,                 0, 0, 0, 0, 3, 32'h44);

    // Reset with both producers requesting
    rst = 1'b1;
    ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    #12;
    chk("reset.ex_ready", 32'(ex_ready), 32'd0);
    chk("reset.lsu_ready", 32'(lsu_ready), 32'd0);
    chk("reset.ex_starved", 32'(ex_starved), 32'd0);
    chk("reset.rf_we", 32'(rf_we), 32'd0);
    chk("reset.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset.rf_wdata", rf_wdata, 32'd0);
    $display("reset: er=%0b lr=%0b st=%0b we=%0b", ex_ready, lsu_ready, ex_starved, rf_we);
    ex_valid = 1'b0; lsu_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i], $sformatf("vec%0d", i));
    end

    // Build lose_cnt to 2 during a write, then pulse reset mid-cycle
    cyc(mk(1, 1, 32'hE1, 1, 2, 32'hC2, 0, 1, 0, 1, 2, 32'hC2), "pre_rst0");
    cyc(mk(1, 1, 32'hE1, 1, 4, 32'hC4, 0, 1, 0, 1, 4, 32'hC4), "pre_rst1");
    #1 rst = 1'b1;
    #1;
    chk("midrst.rf_we", 32'(rf_we), 32'd0);
    chk("midrst.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("midrst.rf_wdata", rf_wdata, 32'd0);
    chk("midrst.ex_ready", 32'(ex_ready), 32'd0);
    chk("midrst.lsu_ready", 32'(lsu_ready), 32'd0);
    chk("midrst.ex_starved", 32'(ex_starved), 32'd0);
    $display("midrst: we=%0b wa=%0d er=%0b lr=%0b", rf_we, rf_waddr, ex_ready, lsu_ready);
    #1 rst = 1'b0;
    // Counter was cleared: three LSU grants before EX wins
    ex_valid = 1'b1; lsu_valid = 1'b1;
    @(negedge clk);
    chk("postrst.lsu_first", 32'(lsu_ready), 32'd1);
    chk("postrst.ex_first", 32'(ex_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("postrst.rf_waddr0", 32'(rf_waddr), 32'd4);
    cyc(mk(1, 1, 32'hE1, 1, 5, 32'hC5, 0, 1, 0, 1, 5, 32'hC5), "post_rst1");
    cyc(mk(1, 1, 32'hE1, 1, 6, 32'hC6, 0, 1, 0, 1, 6, 32'hC6), "post_rst2");
    cyc(mk(1, 1, 32'hE1, 1, 6, 32'hC6, 1, 0, 1, 1, 1, 32'hE1), "post_rst3");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hE1), "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
